path_delay_seq: RTL and testbench

PATH_DELAY_SEQ -- requirements
Module: path_delay_seq

---
 rtl/path_delay_seq.sv | 203 ++++++++++++++++++++
 tb/tb_path_delay_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_delay_seq.sv
// path_delay_seq: measures the launch-to-capture delay of one of N_PATHS external paths.
// Each run performs num_trials launches on the selected path. Before every launch the path
// is allowed to settle, then its input is toggled. The number of clk edges until the
// synchronized output changes is counted, including the SYNC_STAGES synchronizer latency.
//
// Ports:
//   clk, rst_n       single rising-edge clock, asynchronous active-low reset
//   start            begins a run (sampled in IDLE only)
//   abort            cancels a run from any state; takes priority over start
//   path_sel         index of the path under test (latched on start)
//   num_trials       launches per run (latched on start; 0 completes immediately)
//   timeout          maximum MEASURE count per trial (latched on start; 0 means 255)
//   path_in          launch drive into the paths; keeps its level between trials
//   path_out         asynchronous path outputs
//   busy             high in every state except IDLE
//   done             one-cycle pulse when a run completes normally
//   delay_sum        saturating sum of per-trial counts
//   max_delay        largest per-trial count of the run
//   trial_cnt        number of trials completed
//   timeout_err      sticky, set if any trial timed out
module path_delay_seq #(
    parameter int unsigned N_PATHS       = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    localparam int unsigned SelW         = (N_PATHS > 1) ? $clog2(N_PATHS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SelW-1:0]    path_sel,
    input  logic [7:0]         num_trials,
    input  logic [7:0]         timeout,
    output logic [N_PATHS-1:0] path_in,
    input  logic [N_PATHS-1:0] path_out,
    output logic               busy,
    output logic               done,
    output logic [15:0]        delay_sum,
    output logic [7:0]         max_delay,
    output logic [7:0]         trial_cnt,
    output logic               timeout_err
);

    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StLaunch,
        StMeasure,
        StRecord,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [SelW-1:0]                   sel_q, sel_d;
    logic [7:0]                        ntr_q, ntr_d;
    logic [7:0]                        tmo_q, tmo_d;
    logic [SetW-1:0]                   settle_q, settle_d;
    logic [7:0]                        cnt_q, cnt_d;
    logic                              base_q, base_d;
    logic [N_PATHS-1:0]                path_in_q, path_in_d;
    logic [15:0]                       sum_q, sum_d;
    logic [7:0]                        max_q, max_d;
    logic [7:0]                        trials_q, trials_d;
    logic                              terr_q, terr_d;
    logic [SYNC_STAGES-1:0][N_PATHS-1:0] sync_q;

    logic        sync_sel;
    logic [16:0] sum_ext;

    // Synchronizer chains; no reset dependence on FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= path_out;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_sel = sync_q[SYNC_STAGES-1][sel_q];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ntr_d     = ntr_q;
        tmo_d     = tmo_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        path_in_d = path_in_q;
        sum_d     = sum_q;
        max_d     = max_q;
        trials_d  = trials_q;
        terr_d    = terr_q;
        sum_ext   = {1'b0, sum_q} + 17'(cnt_q);

        if (abort) begin
            // Everything else freezes, so results and path_in keep their values.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sel_d    = path_sel;
                        ntr_d    = num_trials;
                        tmo_d    = (timeout == 8'd0) ? 8'hFF : timeout;
                        sum_d    = '0;
                        max_d    = '0;
                        trials_d = '0;
                        terr_d   = 1'b0;
                        settle_d = '0;
                        state_d  = (num_trials == 8'd0) ? StDone : StSettle;
                    end
                end
                StSettle: begin
                    if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
                        base_d  = sync_sel;
                        state_d = StLaunch;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                StLaunch: begin
                    path_in_d[sel_q] = ~path_in_q[sel_q];
                    cnt_d            = '0;
                    state_d          = StMeasure;
                end
                StMeasure: begin
                    // cnt_q equals the number of edges since the launch edge.
                    if (sync_sel != base_q) begin
                        state_d = StRecord;
                    end else if (cnt_q == tmo_q) begin
                        terr_d  = 1'b1;
                        state_d = StRecord;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StRecord: begin
                    sum_d    = sum_ext[16] ? 16'hFFFF : sum_ext[15:0];
                    max_d    = (cnt_q > max_q) ? cnt_q : max_q;
                    trials_d = trials_q + 8'd1;
                    if (trials_d == ntr_q) begin
                        state_d = StDone;
                    end else begin
                        settle_d = '0;
                        state_d  = StSettle;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            ntr_q     <= '0;
            tmo_q     <= '0;
            settle_q  <= '0;
            cnt_q     <= '0;
            base_q    <= 1'b0;
            path_in_q <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            trials_q  <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ntr_q     <= ntr_d;
            tmo_q     <= tmo_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            path_in_q <= path_in_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            trials_q  <= trials_d;
            terr_q    <= terr_d;
        end
    end

    assign path_in     = path_in_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign delay_sum   = sum_q;
    assign max_delay   = max_q;
    assign trial_cnt   = trials_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_path_delay_seq.sv
// Self-checking bench for path_delay_seq: directed runs against a delay-line path model.
module tb_path_delay_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  path_sel;
    logic [7:0]  num_trials;
    logic [7:0]  timeout;
    logic [3:0]  path_in;
    logic [3:0]  path_out;
    logic        busy;
    logic        done;
    logic [15:0] delay_sum;
    logic [7:0]  max_delay;
    logic [7:0]  trial_cnt;
    logic        timeout_err;

    int n_checks = 0;
    int n_bad    = 0;

    path_delay_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .path_sel    (path_sel),
        .num_trials  (num_trials),
        .timeout     (timeout),
        .path_in     (path_in),
        .path_out    (path_out),
        .busy        (busy),
        .done        (done),
        .delay_sum   (delay_sum),
        .max_delay   (max_delay),
        .trial_cnt   (trial_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Path model: per-path delay line; delay d means path_out follows path_in d edges later.
    // The delay of the current trial is looked up by the number of trials already completed.
    logic [15:0] dl [4];
    int          dly_tab [4];
    bit          stuck;
    int          cur_delay;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            dl[i] <= {dl[i][14:0], path_in[i]};
        end
    end

    always_comb begin
        path_out  = '0;
        cur_delay = dly_tab[trial_cnt[1:0]];
        for (int i = 0; i < 4; i++) begin
            path_out[i] = stuck ? 1'b0 : dl[i][cur_delay-1];
        end
    end

    // Event monitor: done pulses and path_in toggles, sampled on the falling edge.
    int         done_total = 0;
    int         tog_total [4];
    logic [3:0] prev_pi = '0;

    initial for (int i = 0; i < 4; i++) tog_total[i] = 0;

    always @(negedge clk) begin
        if (done) done_total <= done_total + 1;
        for (int i = 0; i < 4; i++) begin
            if (path_in[i] != prev_pi[i]) tog_total[i] <= tog_total[i] + 1;
        end
        prev_pi <= path_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle and wait (bounded) for the done pulse.
    task automatic run_trials(input logic [1:0] sel, input logic [7:0] n, input logic [7:0] tmo,
                              output bit ok);
        @(negedge clk);
        path_sel   = sel;
        num_trials = n;
        timeout    = tmo;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit         ok;
        int         d0;
        int         t0;
        logic [3:0] pi0;

        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        path_sel   = '0;
        num_trials = '0;
        timeout    = '0;
        stuck      = 1'b0;
        for (int i = 0; i < 4; i++) dly_tab[i] = 5;
        for (int i = 0; i < 4; i++) dl[i] = '0;

        repeat (20) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", delay_sum, 0);
        check("rst_max", max_delay, 0);
        check("rst_trials", trial_cnt, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_path_in", path_in, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 5-cycle path on sel 0: every trial counts 5 + 2 synchronizer cycles.
        d0 = done_total;
        t0 = tog_total[0];
        run_trials(2'd0, 8'd4, 8'd50, ok);
        check("s1_finish", ok, 1);
        repeat (3) @(negedge clk);
        check("s1_sum", delay_sum, 28);
        check("s1_max", max_delay, 7);
        check("s1_trials", trial_cnt, 4);
        check("s1_terr", timeout_err, 0);
        check("s1_toggles", tog_total[0] - t0, 4);
        check("s1_done_pulses", done_total - d0, 1);
        check("s1_busy", busy, 0);

        // Stuck output: every trial times out at 10.
        stuck = 1'b1;
        d0    = done_total;
        run_trials(2'd1, 8'd2, 8'd10, ok);
        check("s2_finish", ok, 1);
        repeat (3) @(negedge clk);
        check("s2_terr", timeout_err, 1);
        check("s2_sum", delay_sum, 20);
        check("s2_max", max_delay, 10);
        check("s2_trials", trial_cnt, 2);
        check("s2_done_pulses", done_total - d0, 1);
        stuck = 1'b0;
        repeat (20) @(negedge clk);

        // Zero trials: done one cycle after start, results cleared, path_in untouched.
        pi0 = path_in;
        d0  = done_total;
        @(negedge clk);
        path_sel   = 2'd1;
        num_trials = 8'd0;
        timeout    = 8'd50;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s3_done_hi", done, 1);
        @(negedge clk);
        check("s3_done_lo", done, 0);
        check("s3_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("s3_done_pulses", done_total - d0, 1);
        check("s3_sum", delay_sum, 0);
        check("s3_max", max_delay, 0);
        check("s3_trials", trial_cnt, 0);
        check("s3_terr", timeout_err, 0);
        check("s3_path_in", path_in, pi0);

        // Abort during MEASURE of the second trial.
        d0 = done_total;
        t0 = tog_total[0];
        @(negedge clk);
        path_sel   = 2'd0;
        num_trials = 8'd4;
        timeout    = 8'd50;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok    = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (tog_total[0] - t0 >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("s4_reach_trial2", ok, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s4_busy", busy, 0);
        check("s4_trials", trial_cnt, 1);
        repeat (30) @(negedge clk);
        check("s4_no_done", done_total - d0, 0);
        check("s4_sum_held", delay_sum, 7);
        check("s4_busy_later", busy, 0);

        // Delays 3, 9, 4 on sel 2.
        dly_tab[0] = 3;
        dly_tab[1] = 9;
        dly_tab[2] = 4;
        repeat (20) @(negedge clk);
        pi0 = path_in;
        run_trials(2'd2, 8'd3, 8'd50, ok);
        check("s5_finish", ok, 1);
        repeat (3) @(negedge clk);
        check("s5_max", max_delay, 11);
        check("s5_sum", delay_sum, 22);
        check("s5_trials", trial_cnt, 3);
        check("s5_path_in", path_in, pi0 ^ 4'b0100);
        for (int i = 0; i < 4; i++) dly_tab[i] = 5;
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of SETTLE.
        d0 = done_total;
        @(negedge clk);
        path_sel   = 2'd0;
        num_trials = 8'd2;
        timeout    = 8'd50;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("s6_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_busy", busy, 0);
        check("s6_rst_path_in", path_in, 0);
        check("s6_rst_sum", delay_sum, 0);
        check("s6_rst_trials", trial_cnt, 0);
        check("s6_rst_done", done, 0);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("s6_no_done", done_total - d0, 0);
        check("s6_idle", busy, 0);
        d0 = done_total;
        run_trials(2'd3, 8'd2, 8'd50, ok);
        check("s6_finish", ok, 1);
        repeat (3) @(negedge clk);
        check("s6_sum", delay_sum, 14);
        check("s6_max", max_delay, 7);
        check("s6_trials", trial_cnt, 2);
        check("s6_terr", timeout_err, 0);
        check("s6_path_in", path_in, 0);
        check("s6_done_pulses", done_total - d0, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
